// File: rtl/mips_pkg.sv
// Shared definitions for the memory-stage controller: data/register widths,
// the default request timeout and the FSM state encoding.
package mips_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_W       = 5;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request channel: the controller drives the request and
// the memory answers with ready and read data in the completing cycle.
interface mem_stage_ctrl_if;
    import mips_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Request-age counter: load 1, increment with saturation, clear, and flag
// the last request cycle that is still allowed to complete.
module mem_timeout_ctr
    import mips_pkg::*;
#(
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic at_last
);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (inc && (count < CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    // count tracks cycles already spent on the request, so the TIMEOUT-th
    // request cycle is the one seen with count == TIMEOUT-1.
    assign at_last = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage responder between EX/MEM and MEM/WB: issues the data-memory
// access, stalls upstream while it waits, aborts on misalignment or timeout.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] ALUOut_EXMEM,
    input  logic [DATA_W-1:0] MEM_data_EXMEM,
    input  logic [REG_W-1:0]  MEM_Rw,
    input  logic              MemRead_EXMEM,
    input  logic              MemWrite_EXMEM,
    input  logic              MemtoReg_EXMEM,
    input  logic              RegWrite_EXMEM,
    mem_stage_ctrl_if.master  dmem,
    output logic              MemStall,
    output logic              MemErr,
    output logic [DATA_W-1:0] ALUOut_MEMWB,
    output logic [DATA_W-1:0] ReadData_MEMWB,
    output logic [REG_W-1:0]  WB_Rw,
    output logic              RegWrite_MEMWB,
    output logic              MemtoReg_MEMWB
);

    state_t state, next_state;
    logic   access, misaligned, aligned;
    logic   retire, at_last;
    logic   ctr_clr, ctr_load, ctr_inc;

    assign access     = MemRead_EXMEM | MemWrite_EXMEM;
    assign misaligned = access & (ALUOut_EXMEM[1:0] != 2'b00);
    assign aligned    = access & ~misaligned;

    // Read+write together is a write; upstream is frozen while waiting.
    assign dmem.dmem_we    = MemWrite_EXMEM;
    assign dmem.dmem_addr  = ALUOut_EXMEM;
    assign dmem.dmem_wdata = MEM_data_EXMEM;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (ctr_clr),
        .load    (ctr_load),
        .inc     (ctr_inc),
        .at_last (at_last)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (aligned && !dmem.dmem_ready)        next_state = WAIT;
            WAIT: if (dmem.dmem_ready || at_last)         next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        dmem.dmem_req = 1'b0;
        MemStall      = 1'b0;
        MemErr        = 1'b0;
        retire        = 1'b0;
        ctr_clr       = 1'b0;
        ctr_load      = 1'b0;
        ctr_inc       = 1'b0;
        unique case (state)
            IDLE: begin
                dmem.dmem_req = aligned;
                MemErr        = misaligned;
                retire        = aligned & dmem.dmem_ready;
                MemStall      = aligned & ~dmem.dmem_ready;
                ctr_load      = aligned & ~dmem.dmem_ready;
            end
            WAIT: begin
                dmem.dmem_req = 1'b1;
                retire        = dmem.dmem_ready;
                MemErr        = ~dmem.dmem_ready & at_last;
                MemStall      = ~dmem.dmem_ready & ~at_last;
                ctr_inc       = ~dmem.dmem_ready & ~at_last;
                ctr_clr       = dmem.dmem_ready | at_last;
            end
        endcase
    end

    // A stall inserts a bubble into MEM/WB; aborted accesses load with writeback suppressed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALUOut_MEMWB   <= '0;
            ReadData_MEMWB <= '0;
            WB_Rw          <= '0;
            RegWrite_MEMWB <= 1'b0;
            MemtoReg_MEMWB <= 1'b0;
        end else if (MemStall) begin
            RegWrite_MEMWB <= 1'b0;
            MemtoReg_MEMWB <= 1'b0;
        end else begin
            ALUOut_MEMWB   <= ALUOut_EXMEM;
            ReadData_MEMWB <= retire ? dmem.dmem_rdata : '0;
            WB_Rw          <= MEM_Rw;
            RegWrite_MEMWB <= RegWrite_EXMEM & ~MemErr;
            MemtoReg_MEMWB <= MemtoReg_EXMEM;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a driver plays EX/MEM plus a memory
// with chosen latency, a monitor checks every MEM/WB update against the model.
module tb_mem_stage_ctrl;
    import mips_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] ALUOut_EXMEM, MEM_data_EXMEM;
    logic [4:0]  MEM_Rw;
    logic        MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM;
    logic        MemStall, MemErr;
    logic [31:0] ALUOut_MEMWB, ReadData_MEMWB;
    logic [4:0]  WB_Rw;
    logic        RegWrite_MEMWB, MemtoReg_MEMWB;

    mem_stage_ctrl_if dmem_bus ();

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ALUOut_EXMEM   (ALUOut_EXMEM),
        .MEM_data_EXMEM (MEM_data_EXMEM),
        .MEM_Rw         (MEM_Rw),
        .MemRead_EXMEM  (MemRead_EXMEM),
        .MemWrite_EXMEM (MemWrite_EXMEM),
        .MemtoReg_EXMEM (MemtoReg_EXMEM),
        .RegWrite_EXMEM (RegWrite_EXMEM),
        .dmem           (dmem_bus),
        .MemStall       (MemStall),
        .MemErr         (MemErr),
        .ALUOut_MEMWB   (ALUOut_MEMWB),
        .ReadData_MEMWB (ReadData_MEMWB),
        .WB_Rw          (WB_Rw),
        .RegWrite_MEMWB (RegWrite_MEMWB),
        .MemtoReg_MEMWB (MemtoReg_MEMWB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rw;
        logic        regwrite;
        logic        memtoreg;
        logic        err;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      checks = 0;
    int      errors = 0;
    bit      mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_exmem(input logic rd, input logic wr, input logic rgw, input logic m2r,
                               input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rw);
        MemRead_EXMEM  = rd;
        MemWrite_EXMEM = wr;
        RegWrite_EXMEM = rgw;
        MemtoReg_EXMEM = m2r;
        ALUOut_EXMEM   = addr;
        MEM_data_EXMEM = data;
        MEM_Rw         = rw;
    endtask

    // One instruction held in EX/MEM until it leaves; lat = wait states before
    // ready (lat >= TO means memory never answers).
    task automatic run_instr(input logic rd, input logic wr, input logic rgw, input logic m2r,
                             input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rw,
                             input int lat, input logic [31:0] rd_val);
        bit      acc, mis, al, tmo;
        int      n_stall;
        wb_exp_t e;
        acc     = rd | wr;
        mis     = acc && (addr % 4 != 0);
        al      = acc && !mis;
        tmo     = al && (lat >= TO);
        n_stall = !al ? 0 : (tmo ? TO - 1 : lat);
        e.alu      = addr;
        e.rw       = rw;
        e.memtoreg = m2r;
        e.err      = mis | tmo;
        e.regwrite = rgw & ~(mis | tmo);
        e.rdata    = (al && !tmo) ? rd_val : 32'h0;
        sb_q.push_back(e);
        drive_exmem(rd, wr, rgw, m2r, addr, data, rw);
        for (int k = 0; k <= n_stall; k++) begin
            if (al) begin
                dmem_bus.dmem_ready = (k == lat);
                dmem_bus.dmem_rdata = (k == lat) ? rd_val : $urandom;
            end else begin
                dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
                dmem_bus.dmem_rdata = $urandom;
            end
            @(negedge CLK);
            check("dmem_req", dmem_bus.dmem_req, al);
            if (al) begin
                check("dmem_we", dmem_bus.dmem_we, wr);
                check("dmem_addr", dmem_bus.dmem_addr, addr);
                check("dmem_wdata", dmem_bus.dmem_wdata, data);
            end
            check("MemStall", MemStall, k < n_stall);
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: every edge either inserts a bubble (stall seen) or retires the oldest instruction.
    initial begin
        logic        st, er, p_rw;
        logic [31:0] p_alu;
        logic [4:0]  p_wb;
        wb_exp_t     e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                st    = MemStall;
                er    = MemErr;
                p_alu = ALUOut_MEMWB;
                p_wb  = WB_Rw;
                p_rw  = 1'b0;
                @(posedge CLK);
                #1;
                if (st) begin
                    check("stall_no_err", er, p_rw);
                    check("bubble_regwrite", RegWrite_MEMWB, 1'b0);
                    check("bubble_memtoreg", MemtoReg_MEMWB, 1'b0);
                    check("bubble_alu_hold", ALUOut_MEMWB, p_alu);
                    check("bubble_rw_hold", WB_Rw, p_wb);
                end else if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got unexpected MEM/WB update expected none at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("MemErr", er, e.err);
                    check("ALUOut_MEMWB", ALUOut_MEMWB, e.alu);
                    check("ReadData_MEMWB", ReadData_MEMWB, e.rdata);
                    check("WB_Rw", WB_Rw, e.rw);
                    check("RegWrite_MEMWB", RegWrite_MEMWB, e.regwrite);
                    check("MemtoReg_MEMWB", MemtoReg_MEMWB, e.memtoreg);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ALUOut_MEMWB"}, ALUOut_MEMWB, 32'h0);
        check({tag, "_ReadData_MEMWB"}, ReadData_MEMWB, 32'h0);
        check({tag, "_WB_Rw"}, WB_Rw, 32'h0);
        check({tag, "_RegWrite_MEMWB"}, RegWrite_MEMWB, 32'h0);
        check({tag, "_MemtoReg_MEMWB"}, MemtoReg_MEMWB, 32'h0);
        check({tag, "_MemStall"}, MemStall, 32'h0);
        check({tag, "_MemErr"}, MemErr, 32'h0);
        check({tag, "_dmem_req"}, dmem_bus.dmem_req, 32'h0);
        check({tag, "_state"}, dut.state, IDLE);
        check({tag, "_count"}, 32'(dut.u_ctr.count), 32'h0);
    endtask

    initial begin
        logic [31:0] addr;
        int          kind;
        RST = 1'b1;
        drive_exmem(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("por");
        RST    = 1'b0;
        mon_en = 1'b1;

        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678, 5'd0, 3, $urandom);
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd9, 0, $urandom);
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd4, TO + 5, $urandom);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 5'd12, 0, $urandom);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'hA5A5A5A5, 5'd7, 1, $urandom);
        mon_en = 1'b0;

        // Reset while waiting on memory: the second WAIT cycle.
        drive_exmem(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd21);
        dmem_bus.dmem_ready = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        check("rst_pre_stall", MemStall, 1'b1);
        RST = 1'b1;
        drive_exmem(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge CLK);
        #1;
        check_reset_state("wait_rst");
        RST    = 1'b0;
        mon_en = 1'b1;

        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd5, 2, $urandom);
        for (int i = 0; i < 120; i++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_instr(kind[0], kind[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      addr, $urandom, 5'($urandom), $urandom_range(0, TO + 1), $urandom);
        end
        mon_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("sb_drain", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
